vid_timing_gen: RTL and testbench

//  Parametrised raster timing generator; next-generation replacement for the fixed 640x480 counters in the adapter top.

---
 rtl/vid_timing_gen_if.sv | 32 +++
 rtl/vid_timing_gen.sv | 130 +++++++++++++
 tb/tb_vid_timing_gen.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vid_timing_gen_if.sv
// Pixel-timing bundle between a raster timing generator (slave) and its consumer (master).
// Carries the pixel strobe, raster-interrupt controls, look-ahead/output coordinates and syncs.
interface vid_timing_gen_if #(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 10
);
    logic          pix_en;
    logic [YW-1:0] irq_line;
    logic          irq_en;
    logic          irq_ack;
    logic [XW-1:0] pre_x;
    logic [YW-1:0] pre_y;
    logic          pre_de;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          de;
    logic          hsync;
    logic          vsync;
    logic          line_start;
    logic          frame_start;
    logic          irq;

    modport master (
        output pix_en, irq_line, irq_en, irq_ack,
        input  pre_x, pre_y, pre_de, x, y, de, hsync, vsync, line_start, frame_start, irq
    );

    modport slave (
        input  pix_en, irq_line, irq_en, irq_ack,
        output pre_x, pre_y, pre_de, x, y, de, hsync, vsync, line_start, frame_start, irq
    );
endinterface

// File: rtl/vid_timing_gen.sv
// Parametrised raster timing generator: free-running h/v counters, a look-ahead coordinate
// port, a PREFETCH-deep output pipeline with registered syncs, and a latched raster-line irq.
module vid_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned PREFETCH = 2,
    parameter int unsigned XW       = 10,
    parameter int unsigned YW       = 10
) (
    input logic             clk,
    input logic             rst_n,
    vid_timing_gen_if.slave vid
);
    localparam int unsigned HTotal     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HSyncStart = H_ACTIVE + H_FP;
    localparam int unsigned HSyncEnd   = HSyncStart + H_SYNC;
    localparam int unsigned VSyncStart = V_ACTIVE + V_FP;
    localparam int unsigned VSyncEnd   = VSyncStart + V_SYNC;
    localparam int unsigned FW         = $clog2(PREFETCH + 1);

    logic [XW-1:0] hcnt_q, hcnt_d;
    logic [YW-1:0] vcnt_q, vcnt_d;
    logic          pre_de, pre_hs, pre_vs, irq_set;

    logic [XW-1:0] x_q  [PREFETCH];
    logic [YW-1:0] y_q  [PREFETCH];
    logic          de_q [PREFETCH];
    logic          hs_q [PREFETCH];
    logic          vs_q [PREFETCH];

    logic [FW-1:0] fill_q;
    logic          fill_full;
    logic [XW-1:0] feed_x;
    logic [YW-1:0] feed_y;
    logic          line_start_q, frame_start_q, irq_q;

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (vid.pix_en) begin
            if (32'(hcnt_q) == HTotal - 1) begin
                hcnt_d = '0;
                if (32'(vcnt_q) == VTotal - 1) vcnt_d = '0;
                else                           vcnt_d = vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    assign pre_de = (32'(hcnt_q) < H_ACTIVE) && (32'(vcnt_q) < V_ACTIVE);
    assign pre_hs = ((32'(hcnt_q) >= HSyncStart) && (32'(hcnt_q) < HSyncEnd)) ? H_POL : ~H_POL;
    assign pre_vs = ((32'(vcnt_q) >= VSyncStart) && (32'(vcnt_q) < VSyncEnd)) ? V_POL : ~V_POL;

    // fill_full: the stage feeding the output holds real counter data, not reset zeros.
    assign fill_full = (32'(fill_q) == PREFETCH - 1);
    assign irq_set   = vid.pix_en && vid.irq_en && (hcnt_d == '0) && (vcnt_d == vid.irq_line);

    if (PREFETCH == 1) begin : g_feed_cnt
        assign feed_x = hcnt_q;
        assign feed_y = vcnt_q;
    end else begin : g_feed_pipe
        assign feed_x = x_q[PREFETCH-2];
        assign feed_y = y_q[PREFETCH-2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            fill_q        <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            irq_q         <= 1'b0;
            for (int i = 0; i < PREFETCH; i++) begin
                x_q[i]  <= '0;
                y_q[i]  <= '0;
                de_q[i] <= 1'b0;
                hs_q[i] <= ~H_POL;
                vs_q[i] <= ~V_POL;
            end
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            if (vid.pix_en) begin
                x_q[0]  <= hcnt_q;
                y_q[0]  <= vcnt_q;
                de_q[0] <= pre_de;
                hs_q[0] <= pre_hs;
                vs_q[0] <= pre_vs;
                for (int i = 1; i < PREFETCH; i++) begin
                    x_q[i]  <= x_q[i-1];
                    y_q[i]  <= y_q[i-1];
                    de_q[i] <= de_q[i-1];
                    hs_q[i] <= hs_q[i-1];
                    vs_q[i] <= vs_q[i-1];
                end
                if (!fill_full) fill_q <= fill_q + 1'b1;
                line_start_q  <= fill_full && (feed_x == '0);
                frame_start_q <= fill_full && (feed_x == '0) && (feed_y == '0);
            end
            // A set on the same clk as an ack wins.
            if (irq_set)          irq_q <= 1'b1;
            else if (vid.irq_ack) irq_q <= 1'b0;
        end
    end

    assign vid.pre_x       = hcnt_q;
    assign vid.pre_y       = vcnt_q;
    assign vid.pre_de      = pre_de;
    assign vid.x           = x_q[PREFETCH-1];
    assign vid.y           = y_q[PREFETCH-1];
    assign vid.de          = de_q[PREFETCH-1];
    assign vid.hsync       = hs_q[PREFETCH-1];
    assign vid.vsync       = vs_q[PREFETCH-1];
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;
    assign vid.irq         = irq_q;
endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: three instances (default, default-V/small-H, small mode) checked
// against a tick-count raster model under directed and randomized pixel strobes.
module tb_vid_timing_gen;
    localparam int HA  [3] = '{640, 8, 8};
    localparam int HF  [3] = '{16, 1, 1};
    localparam int HS  [3] = '{96, 2, 2};
    localparam int HB  [3] = '{48, 1, 1};
    localparam int VA  [3] = '{480, 480, 4};
    localparam int VF  [3] = '{10, 10, 1};
    localparam int VS  [3] = '{2, 2, 1};
    localparam int VB  [3] = '{33, 33, 1};
    localparam int PF  [3] = '{2, 2, 3};
    localparam int POL [3] = '{0, 0, 1};

    logic       clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0, irq_en = 1'b0, irq_ack = 1'b0;
    logic [9:0] irq_line = '0;
    int         n_cmp = 0, n_err = 0;
    longint     tk = 0;
    logic       last_en = 1'b0;
    logic       eirq [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    vid_timing_gen_if #(.XW(10), .YW(10)) vif0 ();
    vid_timing_gen_if #(.XW(4),  .YW(10)) vif1 ();
    vid_timing_gen_if #(.XW(4),  .YW(3))  vif2 ();

    assign vif0.pix_en = pix_en;    assign vif1.pix_en = pix_en;    assign vif2.pix_en = pix_en;
    assign vif0.irq_en = irq_en;    assign vif1.irq_en = irq_en;    assign vif2.irq_en = irq_en;
    assign vif0.irq_ack = irq_ack;  assign vif1.irq_ack = irq_ack;  assign vif2.irq_ack = irq_ack;
    assign vif0.irq_line = irq_line;
    assign vif1.irq_line = irq_line;
    assign vif2.irq_line = (irq_line < 10'd8) ? irq_line[2:0] : 3'd7;

    vid_timing_gen u_dut0 (.clk(clk), .rst_n(rst_n), .vid(vif0));
    vid_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .XW(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .vid(vif1));
    vid_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
                     .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1), .PREFETCH(3),
                     .XW(4), .YW(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .vid(vif2));

    logic [31:0] o_px [3], o_py [3], o_x [3], o_y [3];
    logic        o_pde [3], o_de [3], o_hs [3], o_vs [3], o_ls [3], o_fs [3], o_irq [3];

    always_comb begin
        o_px[0] = 32'(vif0.pre_x); o_px[1] = 32'(vif1.pre_x); o_px[2] = 32'(vif2.pre_x);
        o_py[0] = 32'(vif0.pre_y); o_py[1] = 32'(vif1.pre_y); o_py[2] = 32'(vif2.pre_y);
        o_x[0] = 32'(vif0.x);      o_x[1] = 32'(vif1.x);      o_x[2] = 32'(vif2.x);
        o_y[0] = 32'(vif0.y);      o_y[1] = 32'(vif1.y);      o_y[2] = 32'(vif2.y);
        o_pde[0] = vif0.pre_de;    o_pde[1] = vif1.pre_de;    o_pde[2] = vif2.pre_de;
        o_de[0] = vif0.de;         o_de[1] = vif1.de;         o_de[2] = vif2.de;
        o_hs[0] = vif0.hsync;      o_hs[1] = vif1.hsync;      o_hs[2] = vif2.hsync;
        o_vs[0] = vif0.vsync;      o_vs[1] = vif1.vsync;      o_vs[2] = vif2.vsync;
        o_ls[0] = vif0.line_start; o_ls[1] = vif1.line_start; o_ls[2] = vif2.line_start;
        o_fs[0] = vif0.frame_start; o_fs[1] = vif1.frame_start; o_fs[2] = vif2.frame_start;
        o_irq[0] = vif0.irq;       o_irq[1] = vif1.irq;       o_irq[2] = vif2.irq;
    end

    // Raster model: position is a pure function of the number of pixel ticks since reset.
    function automatic int htot(int m); return HA[m] + HF[m] + HS[m] + HB[m]; endfunction
    function automatic int vtot(int m); return VA[m] + VF[m] + VS[m] + VB[m]; endfunction
    function automatic int px_of(int m, longint t);
        return int'(t % longint'(htot(m)));
    endfunction
    function automatic int py_of(int m, longint t);
        return int'((t / longint'(htot(m))) % longint'(vtot(m)));
    endfunction
    function automatic int eline(int m);
        return (m == 2 && irq_line >= 10'd8) ? 7 : int'(irq_line);
    endfunction

    function automatic void model(input int m, input longint t, output int x, output int y,
                                  output logic de, output logic hs, output logic vs);
        if (t < longint'(PF[m])) begin
            x = 0; y = 0; de = 1'b0; hs = (POL[m] == 0); vs = (POL[m] == 0);
        end else begin
            x  = px_of(m, t - PF[m]);
            y  = py_of(m, t - PF[m]);
            de = (x < HA[m]) && (y < VA[m]);
            hs = ((x >= HA[m] + HF[m]) && (x < HA[m] + HF[m] + HS[m])) == (POL[m] != 0);
            vs = ((y >= VA[m] + VF[m]) && (y < VA[m] + VF[m] + VS[m])) == (POL[m] != 0);
        end
    endfunction

    function automatic logic e_ls(int m, logic frame);
        int x, y; logic d, h, v;
        model(m, tk, x, y, d, h, v);
        return last_en && (tk >= longint'(PF[m])) && (x == 0) && (!frame || y == 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            tk = 0; last_en = 1'b0;
            for (int m = 0; m < 3; m++) eirq[m] = 1'b0;
        end else begin
            if (pix_en) tk++;
            for (int m = 0; m < 3; m++) begin
                if (pix_en && irq_en && px_of(m, tk) == 0 && py_of(m, tk) == eline(m))
                    eirq[m] = 1'b1;
                else if (irq_ack)
                    eirq[m] = 1'b0;
            end
            last_en = pix_en;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pix_en = 1'b1;
        step(); step();
        for (int m = 0; m < 3; m++) begin
            n_cmp++; if (o_x[m] !== 32'd0 || o_y[m] !== 32'd0) begin n_err++;
                $display("FAIL reset_xy[%0d] got %0d,%0d want 0,0", m, o_x[m], o_y[m]); end
            n_cmp++; if (o_de[m] !== 1'b0) begin n_err++;
                $display("FAIL reset_de[%0d] got %b want 0", m, o_de[m]); end
            n_cmp++; if (o_hs[m] !== (POL[m] == 0) || o_vs[m] !== (POL[m] == 0)) begin n_err++;
                $display("FAIL reset_sync[%0d] got %b%b want idle", m, o_hs[m], o_vs[m]); end
            n_cmp++; if (o_fs[m] !== 1'b0 || o_irq[m] !== 1'b0) begin n_err++;
                $display("FAIL reset_fs_irq[%0d] got %b%b want 00", m, o_fs[m], o_irq[m]); end
        end
    endtask

    task automatic test_first_frame_start();
        int f0 = 0, f2 = 0;
        rst_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (o_fs[0] === 1'b1 && f0 == 0) f0 = c;
            if (o_fs[2] === 1'b1 && f2 == 0) f2 = c;
        end
        n_cmp++; if (f0 != PF[0]) begin n_err++;
            $display("FAIL first_fs_default got clk %0d want %0d", f0, PF[0]); end
        n_cmp++; if (f2 != PF[2]) begin n_err++;
            $display("FAIL first_fs_small got clk %0d want %0d", f2, PF[2]); end
    endtask

    task automatic test_default_line();
        int x, y, hs_low = 0, de_hi = 0, ls_n = 0; logic de, hs, vs;
        pix_en = 1'b1;
        for (int c = 0; c < 800; c++) begin
            step();
            model(0, tk, x, y, de, hs, vs);
            if (o_hs[0] === 1'b0) hs_low++;
            if (o_de[0] === 1'b1) de_hi++;
            if (o_ls[0] === 1'b1) ls_n++;
            n_cmp++; if (o_x[0] !== 32'(x) || o_hs[0] !== hs || o_de[0] !== de) begin n_err++;
                $display("FAIL line_def tk=%0d got x=%0d hs=%b de=%b want x=%0d hs=%b de=%b",
                         tk, o_x[0], o_hs[0], o_de[0], x, hs, de); end
        end
        n_cmp++; if (hs_low != 96) begin n_err++;
            $display("FAIL line_hs_width got %0d want 96", hs_low); end
        n_cmp++; if (de_hi != 640) begin n_err++;
            $display("FAIL line_de_width got %0d want 640", de_hi); end
        n_cmp++; if (ls_n != 1) begin n_err++;
            $display("FAIL line_start_count got %0d want 1", ls_n); end
    endtask

    task automatic test_tall_frame();
        int x, y, vs_low = 0, fs1 = 0, fs2 = 0; logic de, hs, vs;
        pix_en = 1'b1;
        for (int c = 0; c < 6300; c++) begin
            step();
            model(1, tk, x, y, de, hs, vs);
            if (o_vs[1] === 1'b0) vs_low++;
            if (o_fs[1] === 1'b1) fs1++;
            if (o_fs[2] === 1'b1) fs2++;
            n_cmp++; if (o_y[1] !== 32'(y) || o_vs[1] !== vs || o_de[1] !== de) begin n_err++;
                $display("FAIL tall tk=%0d got y=%0d vs=%b de=%b want y=%0d vs=%b de=%b",
                         tk, o_y[1], o_vs[1], o_de[1], y, vs, de); end
            n_cmp++; if (o_px[2] !== 32'(px_of(2, tk)) || o_x[2] !== 32'(px_of(2, tk - 3)))
            begin n_err++;
                $display("FAIL small_lead tk=%0d got pre_x=%0d x=%0d", tk, o_px[2], o_x[2]); end
        end
        n_cmp++; if (vs_low != 24) begin n_err++;
            $display("FAIL tall_vs_width got %0d want 24", vs_low); end
        n_cmp++; if (fs1 != 1 || fs2 != 75) begin n_err++;
            $display("FAIL frame_count got %0d,%0d want 1,75", fs1, fs2); end
    endtask

    task automatic test_toggle();
        int x, y; logic de, hs, vs;
        int fs_at [$];
        for (int c = 0; c < 400; c++) begin
            pix_en = (c % 2 == 0);
            step();
            if (o_fs[2] === 1'b1) fs_at.push_back(c);
            for (int m = 0; m < 3; m++) begin
                model(m, tk, x, y, de, hs, vs);
                n_cmp++;
                if (o_x[m] !== 32'(x) || o_y[m] !== 32'(y) || o_hs[m] !== hs || o_vs[m] !== vs
                    || o_de[m] !== de) begin n_err++;
                    $display("FAIL toggle_out[%0d] c=%0d got %0d,%0d want %0d,%0d",
                             m, c, o_x[m], o_y[m], x, y); end
                n_cmp++; if (o_ls[m] !== e_ls(m, 1'b0) || o_fs[m] !== e_ls(m, 1'b1)) begin
                    n_err++;
                    $display("FAIL toggle_pulse[%0d] c=%0d got ls=%b fs=%b", m, c, o_ls[m],
                             o_fs[m]); end
            end
        end
        n_cmp++;
        if (fs_at.size() < 2) begin n_err++;
            $display("FAIL toggle_period got %0d pulses want >=2", fs_at.size()); end
        else if (fs_at[1] - fs_at[0] != 168) begin n_err++;
            $display("FAIL toggle_period got %0d want 168", fs_at[1] - fs_at[0]); end
    endtask

    task automatic test_irq();
        int guard = 0;
        pix_en = 1'b1; irq_ack = 1'b0; irq_line = 10'd100; irq_en = 1'b1;
        while (tk % 6300 != 1199 && guard < 7000) begin step(); guard++; end
        n_cmp++; if (guard >= 7000) begin n_err++;
            $display("FAIL irq_wait timeout at tk=%0d", tk); end
        n_cmp++; if (o_irq[1] !== 1'b0) begin n_err++;
            $display("FAIL irq_pre got %b want 0", o_irq[1]); end
        irq_ack = 1'b1;
        step();
        n_cmp++; if (o_irq[1] !== 1'b1 || o_py[1] !== 32'd100 || o_px[1] !== 32'd0) begin
            n_err++;
            $display("FAIL irq_set_vs_ack got irq=%b pre=%0d,%0d want 1 at 0,100", o_irq[1],
                     o_px[1], o_py[1]); end
        step();
        n_cmp++; if (o_irq[1] !== 1'b0) begin n_err++;
            $display("FAIL irq_ack_clear got %b want 0", o_irq[1]); end
        irq_ack = 1'b0; irq_line = 10'd600;
        for (int c = 0; c < 6300; c++) begin
            step();
            n_cmp++; if (o_irq[1] !== 1'b0 || o_irq[0] !== 1'b0) begin n_err++;
                $display("FAIL irq_line600 tk=%0d got %b%b want 00", tk, o_irq[0], o_irq[1]); end
        end
    endtask

    task automatic test_random();
        int x, y; logic de, hs, vs;
        for (int c = 0; c < 3000; c++) begin
            pix_en   = ($urandom_range(0, 3) != 0);
            irq_ack  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) irq_en = ~irq_en;
            if ($urandom_range(0, 127) == 0) irq_line = 10'($urandom_range(0, 9));
            step();
            for (int m = 0; m < 3; m++) begin
                model(m, tk, x, y, de, hs, vs);
                n_cmp++; if (o_x[m] !== 32'(x) || o_y[m] !== 32'(y)) begin n_err++;
                    $display("FAIL rand_xy[%0d] tk=%0d got %0d,%0d want %0d,%0d", m, tk,
                             o_x[m], o_y[m], x, y); end
                n_cmp++; if (o_de[m] !== de || o_hs[m] !== hs || o_vs[m] !== vs) begin n_err++;
                    $display("FAIL rand_de_sync[%0d] tk=%0d got %b%b%b want %b%b%b", m, tk,
                             o_de[m], o_hs[m], o_vs[m], de, hs, vs); end
                n_cmp++;
                if (o_px[m] !== 32'(px_of(m, tk)) || o_py[m] !== 32'(py_of(m, tk)) ||
                    o_pde[m] !== (px_of(m, tk) < HA[m] && py_of(m, tk) < VA[m])) begin n_err++;
                    $display("FAIL rand_pre[%0d] tk=%0d got %0d,%0d,%b", m, tk, o_px[m],
                             o_py[m], o_pde[m]); end
                n_cmp++; if (o_ls[m] !== e_ls(m, 1'b0) || o_fs[m] !== e_ls(m, 1'b1)) begin
                    n_err++;
                    $display("FAIL rand_pulse[%0d] tk=%0d got ls=%b fs=%b", m, tk, o_ls[m],
                             o_fs[m]); end
                n_cmp++; if (o_irq[m] !== eirq[m]) begin n_err++;
                    $display("FAIL rand_irq[%0d] tk=%0d got %b want %b", m, tk, o_irq[m],
                             eirq[m]); end
            end
        end
        irq_ack = 1'b0;
    endtask

    task automatic test_midframe_reset();
        int x, y; logic de, hs, vs;
        pix_en = 1'b1; irq_en = 1'b1; irq_line = 10'd0;
        for (int c = 0; c < 90; c++) step();
        #3 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 3; m++) begin
            n_cmp++;
            if (o_x[m] !== 32'd0 || o_y[m] !== 32'd0 || o_px[m] !== 32'd0 || o_py[m] !== 32'd0
                || o_de[m] !== 1'b0 || o_hs[m] !== (POL[m] == 0) || o_vs[m] !== (POL[m] == 0)
                || o_ls[m] !== 1'b0 || o_fs[m] !== 1'b0 || o_irq[m] !== 1'b0) begin n_err++;
                $display("FAIL async_reset[%0d] got x=%0d y=%0d de=%b irq=%b", m, o_x[m],
                         o_y[m], o_de[m], o_irq[m]); end
        end
        irq_en = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            for (int m = 0; m < 3; m++) begin
                model(m, tk, x, y, de, hs, vs);
                n_cmp++; if (o_x[m] !== 32'(x) || o_y[m] !== 32'(y) ||
                             o_fs[m] !== e_ls(m, 1'b1)) begin n_err++;
                    $display("FAIL restart[%0d] tk=%0d got %0d,%0d fs=%b want %0d,%0d", m, tk,
                             o_x[m], o_y[m], o_fs[m], x, y); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame_start();
        test_default_line();
        test_tall_frame();
        test_toggle();
        test_irq();
        test_random();
        test_midframe_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
